register_univ_sr: RTL and testbench
===================================

Name: register_univ_sr

Overview:
- Parametrised universal register: WIDTH-bit state with synchronous clear, parallel load, shift, rotate and modulo up/down count.
- Generalises the fixed 3-bit plain register used for traffic-light state and timer storage.
- Adds mode control, a programmable modulus, a saturate option and a registered wrap flag.
- Sits between the traffic-light FSM next-state logic and the state/timer outputs; one instance per state or counter field.

Parameters:
- WIDTH, 3, register width in bits (>=2).
- RST_VAL, 0, value loaded on reset and on clr (WIDTH bits).
- MAX_VAL, 2**WIDTH-1, terminal count for inc/dec (modulus = MAX_VAL+1); must be <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at terminal count, 1 = hold at terminal count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear to RST_VAL; lower priority than reset.
- en  input  1  operation enable; 0 = hold.
- op  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for shifts.
- q  output  WIDTH  register contents.
- wrap  output  1  registered; pulses high for one cycle after an inc/dec wrap.
- tc  output  1  combinational; q == MAX_VAL for op=inc, q == 0 for op=dec, else 0.

Behaviour:
- One clock domain; clk and reset as above. Reset is synchronous and active-high.
- All state updates occur on the rising clk edge. q and wrap are registered; latency is 1 cycle from inputs to q.
- Reset: q = RST_VAL, wrap = 0. An asynchronous reset edge has no effect until the next clk edge.
- Priority per edge: reset > clr > (en=0: hold) > op.
- clr: q = RST_VAL, wrap = 0; op is ignored.
- en=0: q holds, wrap = 0.
- op encoding with en=1:
  - 000 hold: q unchanged.
  - 001 load: q = d.
  - 010 shl: q = {q[WIDTH-2:0], sin}.
  - 011 shr: q = {sin, q[WIDTH-1:1]}.
  - 100 rotl: q = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotr: q = {q[0], q[WIDTH-1:1]}.
  - 110 inc:
    - q < MAX_VAL: q+1.
    - q >= MAX_VAL, SATURATE=0: q = 0, wrap = 1.
    - q >= MAX_VAL, SATURATE=1: q = MAX_VAL, wrap = 0.
  - 111 dec:
    - q > MAX_VAL: q = MAX_VAL, wrap = 0. This out-of-range clamp applies in both modes.
    - 0 < q <= MAX_VAL: q-1.
    - q == 0, SATURATE=0: q = MAX_VAL, wrap = 1.
    - q == 0, SATURATE=1: q = 0, wrap = 0.
- wrap is 0 on every cycle not listed above.
- Arithmetic is unsigned and WIDTH bits wide; no carry beyond WIDTH.
- A value above MAX_VAL can enter only via load, shift or rotate. inc treats it as terminal.
- d and sin are don't-care except in load and shift ops respectively.
- reset or clr asserted mid-count wins that edge; counting resumes from RST_VAL on the next enabled edge.

Decomposition:
- Shared package holds:
  - Op encodings: OP_HOLD, OP_LOAD, OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_INC, OP_DEC.
  - The 3-bit op type.
  - The traffic-light width constant used by instances.
- One sub-module, dff_r_sync: 1-bit D flip-flop with synchronous active-high reset and a reset-value input.
  - Instantiated WIDTH times via generate for q and once for wrap.
  - Next-state mux and count logic live in the parent.

Test Plan:
- WIDTH=3, RST_VAL=0: assert reset 2 cycles with en=1, op=load, d=7 -> q=0, wrap=0 after each edge. Release reset, same inputs -> q=7 one edge later.
- MAX_VAL=4, SATURATE=0, en=1, op=inc from q=0 for 6 edges -> q = 1,2,3,4,0,1. tc high while q=4. wrap=1 only on the cycle after 4->0.
- MAX_VAL=4, SATURATE=1, op=dec:
  - Load 2, then 4 dec edges -> q = 1,0,0,0; wrap stays 0.
  - Load 6, then dec -> q=4.
- WIDTH=4, load 1011:
  - shl with sin=1 -> 0111.
  - shr with sin=0 -> 0011.
  - rotl from 1011 -> 0111.
  - rotr from 1011 -> 1101.
- Precedence:
  - q=5, en=0, op=inc -> q stays 5 for 3 edges.
  - clr=1 with op=load, d=3 -> q=RST_VAL.
  - reset=1 and clr=1 together -> q=RST_VAL, wrap=0.
- Wrap pulse cleared by reset: q=MAX_VAL, op=inc edge (wrap=1), next edge reset=1 -> wrap=0, q=RST_VAL.

Source files
------------

// File: rtl/register_univ_sr_pkg.sv
// Shared definitions for the universal register: operation encodings and
// the width used by the traffic-light state/timer instances.
package register_univ_sr_pkg;

  localparam int TL_WIDTH = 3;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROTL = 3'b100,
    OP_ROTR = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_e;

endpackage

// File: rtl/register_univ_sr_dff_r_sync.sv
// Single-bit D flip-flop with synchronous active-high reset; the reset value
// arrives on a port so one module serves every bit of any reset pattern.
module dff_r_sync (
  input  logic clk,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      q_o <= rst_val_i;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/register_univ_sr.sv
// Universal WIDTH-bit register: clear, load, shift, rotate and modulo
// up/down count with optional saturation and a registered wrap pulse.
module register_univ_sr
  import register_univ_sr_pkg::*;
#(
  parameter int               WIDTH    = TL_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  op_e              op_sel;
  logic [WIDTH-1:0] q_d;
  logic             wrap_d;

  assign op_sel = op_e'(op);

  always_comb begin
    q_d    = q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = RST_VAL;
    end else if (en) begin
      case (op_sel)
        OP_HOLD: q_d = q;
        OP_LOAD: q_d = d;
        OP_SHL:  q_d = {q[WIDTH-2:0], sin};
        OP_SHR:  q_d = {sin, q[WIDTH-1:1]};
        OP_ROTL: q_d = {q[WIDTH-2:0], q[WIDTH-1]};
        OP_ROTR: q_d = {q[0], q[WIDTH-1:1]};
        OP_INC: begin
          // Anything at or above the terminal count is treated as terminal.
          if (q < MAX_VAL) begin
            q_d = q + ONE;
          end else if (SATURATE) begin
            q_d = MAX_VAL;
          end else begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end
        OP_DEC: begin
          if (q > MAX_VAL) begin
            q_d = MAX_VAL;
          end else if (q != '0) begin
            q_d = q - ONE;
          end else if (SATURATE) begin
            q_d = '0;
          end else begin
            q_d    = MAX_VAL;
            wrap_d = 1'b1;
          end
        end
        default: q_d = q;
      endcase
    end
  end

  always_comb begin
    tc = 1'b0;
    if (op_sel == OP_INC) begin
      tc = (q == MAX_VAL);
    end else if (op_sel == OP_DEC) begin
      tc = (q == '0);
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_q_bit
      dff_r_sync u_q_ff (
        .clk       (clk),
        .rst_i     (reset),
        .rst_val_i (RST_VAL[gi]),
        .d_i       (q_d[gi]),
        .q_o       (q[gi])
      );
    end
  endgenerate

  dff_r_sync u_wrap_ff (
    .clk       (clk),
    .rst_i     (reset),
    .rst_val_i (1'b0),
    .d_i       (wrap_d),
    .q_o       (wrap)
  );

endmodule

// File: tb/tb_register_univ_sr.sv
// Directed bench: three configurations (wrapping mod-5, saturating mod-5,
// 4-bit with non-zero reset value) driven from shared control inputs.
module tb_register_univ_sr;
  import register_univ_sr_pkg::*;

  logic       clk = 1'b0;
  logic       reset, clr, en, sin;
  logic [2:0] op;
  logic [2:0] d3;
  logic [3:0] d4;

  logic [2:0] qa, qb;
  logic [3:0] qc;
  logic       wa, wb, wc, ta, tb, tcc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_univ_sr #(.WIDTH(3), .RST_VAL(3'd0), .MAX_VAL(3'd4), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .op(op), .d(d3), .sin(sin),
    .q(qa), .wrap(wa), .tc(ta));

  register_univ_sr #(.WIDTH(3), .RST_VAL(3'd0), .MAX_VAL(3'd4), .SATURATE(1'b1)) u_b (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .op(op), .d(d3), .sin(sin),
    .q(qb), .wrap(wb), .tc(tb));

  register_univ_sr #(.WIDTH(4), .RST_VAL(4'h9), .MAX_VAL(4'hF), .SATURATE(1'b0)) u_c (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .op(op), .d(d4), .sin(sin),
    .q(qc), .wrap(wc), .tc(tcc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_a [6];
    logic       exp_wa[6];
    logic [2:0] exp_b [6];
    logic [2:0] dec_a [4];
    logic       dec_wa[4];

    exp_a  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    exp_wa = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_b  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    dec_a  = '{3'd1, 3'd0, 3'd4, 3'd3};
    dec_wa = '{1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; clr = 1'b0; en = 1'b1; op = OP_LOAD; sin = 1'b0;
    d3 = 3'd7; d4 = 4'hB;

    // Reset dominates a load for two edges
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("rst%0d_qa", i), qa, 3'd0);
      check($sformatf("rst%0d_wa", i), wa, 1'b0);
      check($sformatf("rst%0d_qc", i), qc, 4'h9);
    end
    reset = 1'b0;
    step();
    check("load_qa", qa, 3'd7);
    check("load_qc", qc, 4'hB);

    // Shifts and rotates on the 4-bit instance
    op = OP_SHL; sin = 1'b1; step();
    check("shl_qc", qc, 4'b0111);
    op = OP_SHR; sin = 1'b0; step();
    check("shr_qc", qc, 4'b0011);
    op = OP_LOAD; step();
    op = OP_ROTL; step();
    check("rotl_qc", qc, 4'b0111);
    op = OP_LOAD; step();
    op = OP_ROTR; step();
    check("rotr_qc", qc, 4'b1101);
    check("rotr_tc", tcc, 1'b0);

    // Count up from 0: wrap vs saturate
    op = OP_LOAD; d3 = 3'd0; step();
    op = OP_INC;
    check("inc_tc0", ta, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("inc%0d_qa", i), qa, exp_a[i]);
      check($sformatf("inc%0d_wa", i), wa, exp_wa[i]);
      check($sformatf("inc%0d_ta", i), ta, exp_a[i] == 3'd4);
      check($sformatf("inc%0d_qb", i), qb, exp_b[i]);
      check($sformatf("inc%0d_wb", i), wb, 1'b0);
    end

    // Count down from 2
    op = OP_LOAD; d3 = 3'd2; step();
    op = OP_DEC;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("dec%0d_qb", i), qb, (i == 0) ? 3'd1 : 3'd0);
      check($sformatf("dec%0d_wb", i), wb, 1'b0);
      check($sformatf("dec%0d_tb", i), tb, i != 0);
      check($sformatf("dec%0d_qa", i), qa, dec_a[i]);
      check($sformatf("dec%0d_wa", i), wa, dec_wa[i]);
    end

    // Out-of-range value clamps to MAX_VAL on dec
    op = OP_LOAD; d3 = 3'd6; step();
    op = OP_DEC; step();
    check("clamp_qb", qb, 3'd4);
    check("clamp_qa", qa, 3'd4);
    check("clamp_wa", wa, 1'b0);

    // Enable low holds
    op = OP_LOAD; d3 = 3'd5; step();
    en = 1'b0; op = OP_INC;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d_qa", i), qa, 3'd5);
      check($sformatf("hold%0d_wa", i), wa, 1'b0);
    end

    // Clear beats load
    en = 1'b1; clr = 1'b1; op = OP_LOAD; d3 = 3'd3; d4 = 4'h3; step();
    check("clr_qa", qa, 3'd0);
    check("clr_qc", qc, 4'h9);
    clr = 1'b0; step();
    check("postclr_qc", qc, 4'h3);

    // Reset and clear together
    reset = 1'b1; clr = 1'b1; step();
    check("rstclr_qc", qc, 4'h9);
    check("rstclr_wc", wc, 1'b0);
    reset = 1'b0; clr = 1'b0;

    // Wrap pulse killed by reset, counting resumes from RST_VAL
    op = OP_LOAD; d3 = 3'd4; d4 = 4'hF; step();
    op = OP_INC; step();
    check("wrap_wa", wa, 1'b1);
    check("wrap_wc", wc, 1'b1);
    check("wrap_qc", qc, 4'h0);
    reset = 1'b1; step();
    check("wraprst_wa", wa, 1'b0);
    check("wraprst_wc", wc, 1'b0);
    check("wraprst_qc", qc, 4'h9);
    reset = 1'b0; step();
    check("resume_qa", qa, 3'd1);
    check("resume_qc", qc, 4'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
